// File: rtl/keypad_operand_entry_pkg.sv
// Shared definitions for the keypad operand entry block.
//   - key-code constants decoded by the entry FSM
//   - entry_state_t: the three-phase entry/hand-off sequence
//   - signed_commit(): magnitude + sign -> two's complement, width MAX_OP_W
package keypad_operand_entry_pkg;

  // Widest operand the commit helper supports; callers size-cast the result.
  localparam int MAX_OP_W = 32;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_SIGN      = 4'hA;
  localparam logic [3:0] KEY_BACK      = 4'hB;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_ENTER     = 4'hD;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    HANDOFF = 2'd2
  } entry_state_t;

  // A negative zero is folded to plain zero so "-0" never reaches the multiplier.
  function automatic logic [MAX_OP_W-1:0] signed_commit(input logic [MAX_OP_W-1:0] mag,
                                                        input logic                neg);
    if (neg && (mag != '0)) begin
      return -mag;
    end
    return mag;
  endfunction

endpackage

// File: rtl/keypad_operand_entry_if.sv
// Operand hand-off bus towards the Booth multiplier core.
//   op_a / op_b : committed signed operands (master -> slave)
//   op_valid    : operand pair available    (master -> slave)
//   op_ready    : multiplier accepts pair   (slave  -> master)
interface keypad_operand_entry_if #(
  parameter int OP_W = 8
) ();
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            op_valid;
  logic            op_ready;

  modport master (output op_a, output op_b, output op_valid, input op_ready);
  modport slave  (input op_a, input op_b, input op_valid, output op_ready);
endinterface

// File: rtl/keypad_operand_entry_digit_accumulator.sv
// Decimal digit accumulator for the field currently being edited.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_digit_valid  : append i_digit (0..9) to the magnitude
//   i_back         : drop the last entered digit
//   i_sign         : toggle the sign flag
//   i_clear        : zero magnitude, digit count and sign (has priority)
//   o_mag, o_neg   : magnitude and sign of the field
//   o_reject       : one-cycle pulse when a digit was refused
module digit_accumulator
  import keypad_operand_entry_pkg::*;
#(
  parameter int OP_W       = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_digit_valid,
  input  logic [3:0]      i_digit,
  input  logic            i_back,
  input  logic            i_sign,
  input  logic            i_clear,
  output logic [OP_W-1:0] o_mag,
  output logic            o_neg,
  output logic            o_reject
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  // mag*10+9 stays below 2^(OP_W+3) since mag <= 2^(OP_W-1)-1.
  localparam int EXT_W = OP_W + 4;
  localparam logic [EXT_W-1:0] MAX_MAG   = {{5{1'b0}}, {(OP_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] DIG_LIMIT = CNT_W'(MAX_DIGITS);

  logic [OP_W-1:0]  r_mag;
  logic [CNT_W-1:0] r_count;
  logic             r_neg;
  logic             r_reject;

  logic [EXT_W-1:0] w_candidate;
  logic             w_accept;

  assign w_candidate = ({4'b0000, r_mag} * EXT_W'(10)) + EXT_W'(i_digit);
  assign w_accept    = (r_count < DIG_LIMIT) && (w_candidate <= MAX_MAG);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_mag    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      if (i_digit_valid) begin
        if (w_accept) begin
          r_mag   <= w_candidate[OP_W-1:0];
          r_count <= r_count + 1'b1;
        end else begin
          r_reject <= 1'b1;
        end
      end else if (i_back) begin
        if (r_count != '0) begin
          r_mag   <= r_mag / OP_W'(10);
          r_count <= r_count - 1'b1;
        end
      end else if (i_sign) begin
        r_neg <= ~r_neg;
      end
    end
  end

  assign o_mag    = r_mag;
  assign o_neg    = r_neg;
  assign o_reject = r_reject;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: builds two signed decimal operands from key codes
// and hands the pair to the multiplier over a valid/ready handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   key_valid, key_code : one-cycle debounced key strobe and its code
//   op_bus (master)     : op_a, op_b, op_valid out; op_ready in
//   disp_mag, disp_neg  : magnitude/sign of the field being edited
//   disp_field          : 0 = editing A, 1 = editing B (or awaiting hand-off)
//   ovf_pulse           : one-cycle pulse on a rejected digit
module keypad_operand_entry
  import keypad_operand_entry_pkg::*;
#(
  parameter int OP_W       = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  keypad_operand_entry_if.master op_bus,
  output logic [OP_W-1:0]        disp_mag,
  output logic                   disp_neg,
  output logic                   disp_field,
  output logic                   ovf_pulse
);

  entry_state_t    r_state;
  entry_state_t    w_state_next;
  logic [OP_W-1:0] r_op_a;
  logic [OP_W-1:0] r_op_b;

  logic            w_acc_digit;
  logic            w_acc_back;
  logic            w_acc_sign;
  logic            w_acc_clear;
  logic            w_commit_a;
  logic            w_commit_b;
  logic            w_zero_ops;
  logic [OP_W-1:0] w_mag;
  logic            w_neg;
  logic [OP_W-1:0] w_commit_val;

  assign w_commit_val = OP_W'(signed_commit(MAX_OP_W'(w_mag), w_neg));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_op_a  <= '0;
      r_op_b  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_zero_ops) begin
        r_op_a <= '0;
        r_op_b <= '0;
      end else begin
        if (w_commit_a) r_op_a <= w_commit_val;
        if (w_commit_b) r_op_b <= w_commit_val;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_digit  = 1'b0;
    w_acc_back   = 1'b0;
    w_acc_sign   = 1'b0;
    w_acc_clear  = 1'b0;
    w_commit_a   = 1'b0;
    w_commit_b   = 1'b0;
    w_zero_ops   = 1'b0;
    // CLEAR aborts from any state, including the transfer cycle itself.
    if (key_valid && (key_code == KEY_CLEAR)) begin
      w_state_next = ENTER_A;
      w_acc_clear  = 1'b1;
      w_zero_ops   = 1'b1;
    end else if (r_state == HANDOFF) begin
      // Display keeps B's value until the pair is taken.
      if (op_bus.op_ready) begin
        w_state_next = ENTER_A;
        w_acc_clear  = 1'b1;
      end
    end else if (key_valid) begin
      case (key_code)
        KEY_SIGN: w_acc_sign = 1'b1;
        KEY_BACK: w_acc_back = 1'b1;
        KEY_ENTER: begin
          if (r_state == ENTER_A) begin
            w_commit_a   = 1'b1;
            w_acc_clear  = 1'b1;
            w_state_next = ENTER_B;
          end else begin
            w_commit_b   = 1'b1;
            w_state_next = HANDOFF;
          end
        end
        default: w_acc_digit = (key_code <= KEY_DIGIT_MAX);
      endcase
    end
  end

  digit_accumulator #(
    .OP_W       (OP_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk           (clk),
    .rst           (rst),
    .i_digit_valid (w_acc_digit),
    .i_digit       (key_code),
    .i_back        (w_acc_back),
    .i_sign        (w_acc_sign),
    .i_clear       (w_acc_clear),
    .o_mag         (w_mag),
    .o_neg         (w_neg),
    .o_reject      (ovf_pulse)
  );

  assign op_bus.op_a     = r_op_a;
  assign op_bus.op_b     = r_op_b;
  assign op_bus.op_valid = (r_state == HANDOFF);
  assign disp_mag        = w_mag;
  assign disp_neg        = w_neg;
  assign disp_field      = (r_state != ENTER_A);

endmodule

// File: tb/tb_keypad_operand_entry.sv
module tb_keypad_operand_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        kv8 = 1'b0, kv12 = 1'b0;
  logic [3:0]  kc8 = 4'h0, kc12 = 4'h0;
  logic [7:0]  mag8;
  logic [11:0] mag12;
  logic        neg8, field8, ovf8, neg12, field12, ovf12;

  keypad_operand_entry_if #(.OP_W(8))  bus8 ();
  keypad_operand_entry_if #(.OP_W(12)) bus12 ();

  keypad_operand_entry #(.OP_W(8), .MAX_DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .key_valid(kv8), .key_code(kc8), .op_bus(bus8),
    .disp_mag(mag8), .disp_neg(neg8), .disp_field(field8), .ovf_pulse(ovf8)
  );

  keypad_operand_entry #(.OP_W(12), .MAX_DIGITS(4)) dut12 (
    .clk(clk), .rst(rst), .key_valid(kv12), .key_code(kc12), .op_bus(bus12),
    .disp_mag(mag12), .disp_neg(neg12), .disp_field(field12), .ovf_pulse(ovf12)
  );

  int n_checks = 0;
  int n_errors = 0;
  int v8_cycles = 0;
  logic [15:0] sb8[$];
  logic [23:0] sb12[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic press(input int w, input logic [3:0] code);
    @(negedge clk);
    if (w == 8) begin kv8 = 1'b1; kc8 = code; end
    else        begin kv12 = 1'b1; kc12 = code; end
    @(negedge clk);
    kv8 = 1'b0;
    kv12 = 1'b0;
  endtask

  // Scoreboard monitors: sample half a cycle before the edge that transfers.
  always @(negedge clk) begin
    #1;
    if (!rst && bus8.op_valid) v8_cycles++;
    if (!rst && bus8.op_valid && bus8.op_ready) begin
      check("sb8_pending", 32'(sb8.size() != 0), 1);
      if (sb8.size() != 0) begin
        logic [15:0] e;
        e = sb8.pop_front();
        check("xfer8_a", bus8.op_a, e[15:8]);
        check("xfer8_b", bus8.op_b, e[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst && bus12.op_valid && bus12.op_ready) begin
      check("sb12_pending", 32'(sb12.size() != 0), 1);
      if (sb12.size() != 0) begin
        logic [23:0] e;
        e = sb12.pop_front();
        check("xfer12_a", bus12.op_a, e[23:12]);
        check("xfer12_b", bus12.op_b, e[11:0]);
      end
    end
  end

  initial begin
    bus8.op_ready  = 1'b1;
    bus12.op_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_op_a", bus8.op_a, 0);
    check("rst_op_b", bus8.op_b, 0);
    check("rst_valid", bus8.op_valid, 0);
    check("rst_mag", mag8, 0);
    check("rst_neg", neg8, 0);
    check("rst_field", field8, 0);
    check("rst_ovf", ovf8, 0);

    // 123 ENTER -45 ENTER, ready held high
    press(8, 4'h1); press(8, 4'h2); press(8, 4'h3);
    check("s1_mag123", mag8, 123);
    press(8, 4'hD);
    check("s1_op_a", bus8.op_a, 8'h7B);
    check("s1_field_b", field8, 1);
    check("s1_mag_clr", mag8, 0);
    press(8, 4'h4); press(8, 4'h5); press(8, 4'hA);
    check("s1_mag45", mag8, 45);
    check("s1_neg", neg8, 1);
    v8_cycles = 0;
    sb8.push_back({8'h7B, 8'hD3});
    press(8, 4'hD);
    check("s1_valid", bus8.op_valid, 1);
    @(negedge clk);
    check("s1_valid_drop", bus8.op_valid, 0);
    check("s1_field_a", field8, 0);
    check("s1_mag_after", mag8, 0);
    check("s1_hold_a", bus8.op_a, 8'h7B);
    check("s1_hold_b", bus8.op_b, 8'hD3);
    check("s1_valid_cycles", v8_cycles, 1);

    // -0 commits as 0
    press(8, 4'hA);
    check("neg0_sign", neg8, 1);
    press(8, 4'hD);
    check("neg0_op_a", bus8.op_a, 0);
    check("neg0_neg_clr", neg8, 0);
    press(8, 4'hC);

    // Magnitude limit
    press(8, 4'h1); press(8, 4'h2); press(8, 4'h8);
    check("lim_ovf128", ovf8, 1);
    check("lim_mag12", mag8, 12);
    @(negedge clk);
    check("lim_ovf_pulse", ovf8, 0);
    press(8, 4'h7);
    check("lim_mag127", mag8, 127);
    check("lim_ovf_none", ovf8, 0);
    press(8, 4'h1);
    check("lim_cnt_ovf", ovf8, 1);
    check("lim_mag_hold", mag8, 127);
    press(8, 4'hE);
    check("ign_E_ovf", ovf8, 0);
    check("ign_E_mag", mag8, 127);
    press(8, 4'hC);

    // Leading zeros, digit-count limit, backspace floor
    press(8, 4'h0); press(8, 4'h0); press(8, 4'h1);
    check("lz_mag1", mag8, 1);
    press(8, 4'h5);
    check("lz_ovf", ovf8, 1);
    check("lz_mag_hold", mag8, 1);
    press(8, 4'hB);
    check("bk_mag0", mag8, 0);
    press(8, 4'hB); press(8, 4'hB); press(8, 4'hB);
    check("bk_floor", mag8, 0);
    check("bk_no_ovf", ovf8, 0);
    press(8, 4'h1); press(8, 4'h2); press(8, 4'h3);
    check("bk_count_zero", mag8, 123);
    press(8, 4'hB);
    check("bk_div10", mag8, 12);
    press(8, 4'hC);

    // Back-pressure: pair 12, -3 held while keys are pressed
    press(8, 4'h1); press(8, 4'h2); press(8, 4'hD);
    press(8, 4'h3); press(8, 4'hA);
    bus8.op_ready = 1'b0;
    sb8.push_back({8'h0C, 8'hFD});
    press(8, 4'hD);
    for (int i = 0; i < 6; i++) begin
      press(8, 4'h7);
      check("bp_valid", bus8.op_valid, 1);
      check("bp_op_a", bus8.op_a, 8'h0C);
      check("bp_op_b", bus8.op_b, 8'hFD);
      check("bp_disp", mag8, 3);
    end
    @(negedge clk);
    bus8.op_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", bus8.op_valid, 0);
    check("bp_field_a", field8, 0);
    check("bp_disp_clr", mag8, 0);

    // CLEAR in ENTER_B
    press(8, 4'h1); press(8, 4'hD); press(8, 4'h9);
    check("clrb_mag9", mag8, 9);
    press(8, 4'hC);
    check("clrb_field", field8, 0);
    check("clrb_mag", mag8, 0);
    check("clrb_op_a", bus8.op_a, 0);

    // CLEAR in HANDOFF withdraws op_valid without op_ready
    bus8.op_ready = 1'b0;
    press(8, 4'h5); press(8, 4'hD); press(8, 4'h6); press(8, 4'hD);
    check("clrh_valid", bus8.op_valid, 1);
    press(8, 4'hC);
    check("clrh_valid_drop", bus8.op_valid, 0);
    check("clrh_op_b", bus8.op_b, 0);
    bus8.op_ready = 1'b1;

    // rst mid ENTER_B
    press(8, 4'h4); press(8, 4'hD); press(8, 4'h5);
    check("rstb_field", field8, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rstb_op_a", bus8.op_a, 0);
    check("rstb_field0", field8, 0);
    check("rstb_mag", mag8, 0);
    check("rstb_valid", bus8.op_valid, 0);

    // OP_W=12, MAX_DIGITS=4
    press(12, 4'h2); press(12, 4'h0); press(12, 4'h4); press(12, 4'h7);
    check("w12_mag2047", mag12, 2047);
    check("w12_no_ovf", ovf12, 0);
    press(12, 4'hD);
    check("w12_op_a", bus12.op_a, 12'h7FF);
    press(12, 4'h2); press(12, 4'h0); press(12, 4'h4); press(12, 4'h8);
    check("w12_ovf2048", ovf12, 1);
    check("w12_mag204", mag12, 204);
    press(12, 4'hC);
    press(12, 4'h1); press(12, 4'h2); press(12, 4'h3); press(12, 4'hD);
    press(12, 4'h4); press(12, 4'h5); press(12, 4'hA);
    sb12.push_back({12'h07B, 12'hFD3});
    press(12, 4'hD);
    check("w12_valid", bus12.op_valid, 1);
    @(negedge clk);
    check("w12_valid_drop", bus12.op_valid, 0);
    check("w12_field", field12, 0);

    repeat (2) @(negedge clk);
    check("sb8_drained", sb8.size(), 0);
    check("sb12_drained", sb12.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
